// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the LSU,
// with one outstanding transaction, starvation protection for IF and fetch flush.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  lsu_req,
  input  logic                  lsu_we,
  input  logic [DATA_W/8-1:0]   lsu_be,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic [DATA_W-1:0]     lsu_wdata,
  output logic                  lsu_gnt,
  output logic                  lsu_rvalid,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_IF  = 2'd1;
  localparam logic [1:0] WAIT_LSU = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             drop_flag_q, drop_flag_d;

  logic idle, sel_if, sel_lsu;

  assign idle    = (state_q == IDLE);
  assign sel_if  = idle & if_req & (~lsu_req | (starve_cnt_q == MAX_CNT));
  assign sel_lsu = idle & lsu_req & ~sel_if;

  assign mem_req   = sel_if | sel_lsu;
  assign mem_we    = sel_lsu & lsu_we;
  assign mem_be    = sel_if ? {BE_W{1'b1}} : (sel_lsu ? lsu_be : '0);
  assign mem_addr  = sel_if ? if_addr : (sel_lsu ? lsu_addr : '0);
  assign mem_wdata = sel_lsu ? lsu_wdata : '0;

  assign if_gnt  = sel_if & mem_gnt;
  assign lsu_gnt = sel_lsu & mem_gnt;

  // A flush on the response cycle itself must also hide the data.
  assign if_rvalid  = (state_q == WAIT_IF) & mem_rvalid & ~drop_flag_q & ~if_flush;
  assign lsu_rvalid = (state_q == WAIT_LSU) & mem_rvalid;
  assign if_rdata   = mem_rdata;
  assign lsu_rdata  = mem_rdata;
  assign busy       = ~idle;

  always_comb begin
    state_d     = state_q;
    drop_flag_d = drop_flag_q;
    case (state_q)
      IDLE: begin
        if (if_gnt) begin
          state_d     = WAIT_IF;
          drop_flag_d = if_flush;
        end else if (lsu_gnt) begin
          state_d = WAIT_LSU;
        end
      end
      WAIT_IF: begin
        if (mem_rvalid) begin
          state_d     = IDLE;
          drop_flag_d = 1'b0;
        end else if (if_flush) begin
          drop_flag_d = 1'b1;
        end
      end
      WAIT_LSU: begin
        if (mem_rvalid) state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        drop_flag_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_gnt)
      starve_cnt_d = '0;
    else if (lsu_gnt && starve_cnt_q != MAX_CNT)
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      drop_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      drop_flag_q  <= drop_flag_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single-port memory between the instruction-fetch stage (IF) and the load/store unit (LSU).
- Arbitrates between the two requesters and keeps at most one transaction outstanding.
- Routes each response back to the requester that owns it.
- Lets the pipeline cancel an in-flight fetch after a taken branch or jump, without disturbing the memory protocol.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_WAIT, 3, number of consecutive LSU grants allowed while if_req is pending before IF is forced ahead (must be >= 1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  discard the response of any in-flight fetch.
- if_gnt  out  1  fetch accepted by memory this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DATA_W  fetch data.
- lsu_req  in  1  load/store request; held with lsu_we, lsu_be, lsu_addr and lsu_wdata stable until lsu_gnt.
- lsu_we  in  1  1 = store.
- lsu_be  in  DATA_W/8  byte enables.
- lsu_addr  in  ADDR_W  data address.
- lsu_wdata  in  DATA_W  store data.
- lsu_gnt  out  1  LSU request accepted this cycle.
- lsu_rvalid  out  1  load data valid or store complete.
- lsu_rdata  out  DATA_W  load data.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_be  out  DATA_W/8  byte enables.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  write data.
- mem_gnt  in  1  memory accepts mem_req this cycle.
- mem_rvalid  in  1  response valid; exactly one per accepted request, for loads and stores alike.
- mem_rdata  in  DATA_W  response data.
- busy  out  1  transaction in flight (state != IDLE).

Behaviour:
- FSM states: IDLE, WAIT_IF, WAIT_LSU.
- Reset values: state = IDLE, starve_cnt = 0, drop_flag = 0.
  - All outputs 0 in reset and IDLE except the combinational paths described below.
  - if_rdata and lsu_rdata are continuous copies of mem_rdata; they are meaningful only while the matching rvalid is high.
- Arbitration in IDLE is combinational, same cycle:
  - sel_if = if_req & (~lsu_req | starve_cnt == MAX_WAIT).
  - sel_lsu = lsu_req & ~sel_if.
- mem_req = IDLE & (if_req | lsu_req).
  - mem_addr/we/be/wdata mux from the selected requester.
  - An IF access drives we = 0 and be = all ones.
  - With no request, the mem_* data fields are 0.
- mem_req stays high while mem_gnt is low; the selection may change between cycles only if the starvation rule forces it.
- IDLE & mem_req & mem_gnt:
  - Pulse if_gnt or lsu_gnt (one cycle, combinational on mem_gnt).
  - Next state is WAIT_IF or WAIT_LSU.
- mem_req = 0 in WAIT_* states: single outstanding transaction only.
- WAIT_x & mem_rvalid:
  - Assert x_rvalid the same cycle (combinational).
  - Return to IDLE.
  - The next grant comes no earlier than the following cycle, so minimum spacing between grants is 2 cycles with zero-latency memory.
- starve_cnt, width $clog2(MAX_WAIT+1):
  - +1 on each lsu grant while if_req = 1, saturating at MAX_WAIT.
  - Cleared on an if grant.
  - Cleared in any cycle with if_req = 0.
- Flush:
  - drop_flag is set when if_flush = 1 in WAIT_IF, or in IDLE on the cycle of an if grant.
  - While drop_flag or if_flush is high, if_rvalid is forced to 0 in WAIT_IF.
  - The FSM still waits for mem_rvalid, then clears drop_flag on return to IDLE.
  - if_flush in WAIT_LSU or in IDLE without an if grant has no effect.
  - if_flush never affects lsu_*.
- mem_rvalid in IDLE (stray or pre-reset response) is ignored: no rvalid to either requester.
- Asynchronous reset mid-transaction returns to IDLE at once and drops the outstanding response.
- mem_gnt and mem_rvalid in the same cycle are legal:
  - In IDLE only gnt is acted on.
  - The response then arrives in a WAIT state on a later cycle.

Test Plan:
- if_req alone, addr 0x100; mem grants at once, rvalid 1 cycle later with 0xDEADBEEF -> if_gnt in cycle 0, if_rvalid with 0xDEADBEEF in cycle 1, busy high for exactly 1 cycle.
- if_req and lsu_req (store, addr 0x2000, wdata 0x55AA, be 4'b0011) in the same cycle -> LSU granted first, mem_we = 1, mem_be = 0011; IF granted on the next IDLE.
- lsu_req held continuously with if_req pending, MAX_WAIT = 3 -> 3 LSU grants, then the 4th grant goes to IF; starve_cnt returns to 0.
- Fetch granted, if_flush pulsed in WAIT_IF, rvalid 2 cycles later -> if_rvalid stays 0, state returns to IDLE, the next if_req is served normally.
- mem_gnt held low for 4 cycles with lsu_req -> mem_req and its fields stay stable and no gnt is issued; on mem_gnt, lsu_gnt pulses once.
- rst asserted in WAIT_LSU, then mem_rvalid after release -> outputs 0 immediately, lsu_rvalid never asserted, busy = 0.
